// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the integer register file: ALU/load arbitration onto one write port plus
// a pending-write scoreboard that stalls issue. Define REGFILE_WB_BYPASS_EN for same-cycle bypass.
module regfile_wb_arbiter #(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_alu_valid,
   input  logic [4:0]      i_alu_rd,
   input  logic [XLEN-1:0] i_alu_data,
   output logic            o_alu_ready,
   input  logic            i_ld_valid,
   input  logic [4:0]      i_ld_rd,
   input  logic [XLEN-1:0] i_ld_data,
   output logic            o_ld_ready,
   output logic            o_w_enable,
   output logic [4:0]      o_write_entry,
   output logic [XLEN-1:0] o_write_value,
   input  logic            i_issue_valid,
   input  logic [4:0]      i_issue_rs1,
   input  logic [4:0]      i_issue_rs2,
   input  logic [4:0]      i_issue_rd,
   input  logic            i_issue_has_rd,
   output logic            o_issue_ready,
   input  logic            i_flush,
   output logic            o_fwd_rs1_hit,
   output logic            o_fwd_rs2_hit,
   output logic [XLEN-1:0] o_fwd_data
);

   localparam logic [3:0] MaxWaitCnt = 4'(MAX_WAIT);

   logic [3:0]      r_wait_cnt;
   logic [31:0]     r_busy;

   logic            w_alu_grant;
   logic            w_ld_grant;
   logic [4:0]      w_gnt_rd;
   logic [XLEN-1:0] w_gnt_data;
   logic            w_we;
   logic            w_rs1_busy;
   logic            w_rs2_busy;
   logic            w_rd_busy;
   logic            w_fwd1;
   logic            w_fwd2;
   logic            w_hazard;
   logic            w_issue_ok;
   logic [31:0]     w_set;
   logic [31:0]     w_clr;

   // Load has priority unless the ALU has been denied MAX_WAIT consecutive cycles.
   assign w_alu_grant = i_alu_valid & (~i_ld_valid | (r_wait_cnt == MaxWaitCnt));
   assign w_ld_grant  = i_ld_valid & ~w_alu_grant;

   always_comb begin
      w_gnt_rd   = 5'd0;
      w_gnt_data = '0;
      if (w_alu_grant) begin
         w_gnt_rd   = i_alu_rd;
         w_gnt_data = i_alu_data;
      end else if (w_ld_grant) begin
         w_gnt_rd   = i_ld_rd;
         w_gnt_data = i_ld_data;
      end
   end

   assign w_we = ~rst & (w_alu_grant | w_ld_grant) & (w_gnt_rd != 5'd0);

`ifdef REGFILE_WB_BYPASS_EN
   assign w_fwd1 = w_we & (w_gnt_rd == i_issue_rs1);
   assign w_fwd2 = w_we & (w_gnt_rd == i_issue_rs2);
   assign w_rs1_busy = r_busy[i_issue_rs1] & ~w_fwd1;
   assign w_rs2_busy = r_busy[i_issue_rs2] & ~w_fwd2;
   assign w_rd_busy  = r_busy[i_issue_rd] & ~(w_we & (w_gnt_rd == i_issue_rd));
`else
   assign w_fwd1     = 1'b0;
   assign w_fwd2     = 1'b0;
   assign w_rs1_busy = r_busy[i_issue_rs1];
   assign w_rs2_busy = r_busy[i_issue_rs2];
   assign w_rd_busy  = r_busy[i_issue_rd];
`endif

   // busy[0] is held at 0, so index-0 sources never contribute a hazard.
   assign w_hazard   = i_issue_valid & (w_rs1_busy | w_rs2_busy | (i_issue_has_rd & w_rd_busy));
   assign w_issue_ok = i_issue_valid & ~w_hazard & ~i_flush;

   assign w_set = (w_issue_ok & i_issue_has_rd) ? (32'd1 << i_issue_rd) : 32'd0;
   assign w_clr = w_we ? (32'd1 << w_gnt_rd) : 32'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt <= 4'd0;
         r_busy     <= 32'd0;
      end else begin
         if (!i_alu_valid || w_alu_grant) begin
            r_wait_cnt <= 4'd0;
         end else if (r_wait_cnt < MaxWaitCnt) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
         end
         if (i_flush) begin
            r_busy <= 32'd0;
         end else begin
            r_busy <= ((r_busy & ~w_clr) | w_set) & 32'hFFFF_FFFE;
         end
      end
   end

   assign o_alu_ready   = ~rst & w_alu_grant;
   assign o_ld_ready    = ~rst & w_ld_grant;
   assign o_w_enable    = w_we;
   assign o_write_entry = rst ? 5'd0 : w_gnt_rd;
   assign o_write_value = rst ? '0 : w_gnt_data;
   assign o_issue_ready = ~rst & w_issue_ok;
   assign o_fwd_rs1_hit = w_fwd1;
   assign o_fwd_rs2_hit = w_fwd2;
`ifdef REGFILE_WB_BYPASS_EN
   assign o_fwd_data    = o_write_value;
`else
   assign o_fwd_data    = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (default build; bypass expectations
// selected by REGFILE_WB_BYPASS_EN).
module tb_regfile_wb_arbiter;

   localparam int unsigned XLEN = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            alu_valid, ld_valid, issue_valid, issue_has_rd, flush;
   logic [4:0]      alu_rd, ld_rd, issue_rs1, issue_rs2, issue_rd;
   logic [XLEN-1:0] alu_data, ld_data;
   logic            alu_ready, ld_ready, w_enable, issue_ready, fwd_rs1_hit, fwd_rs2_hit;
   logic [4:0]      write_entry;
   logic [XLEN-1:0] write_value, fwd_data;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.XLEN(XLEN), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data), .o_alu_ready(alu_ready),
      .i_ld_valid(ld_valid), .i_ld_rd(ld_rd), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
      .o_w_enable(w_enable), .o_write_entry(write_entry), .o_write_value(write_value),
      .i_issue_valid(issue_valid), .i_issue_rs1(issue_rs1), .i_issue_rs2(issue_rs2),
      .i_issue_rd(issue_rd), .i_issue_has_rd(issue_has_rd), .o_issue_ready(issue_ready),
      .i_flush(flush), .o_fwd_rs1_hit(fwd_rs1_hit), .o_fwd_rs2_hit(fwd_rs2_hit),
      .o_fwd_data(fwd_data)
   );

   task automatic idle();
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      ld_valid = 0; ld_rd = 0; ld_data = 0;
      issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_has_rd = 0;
      flush = 0;
   endtask

   // Inputs change at posedge+1; outputs are sampled at the following negedge.
   task automatic next();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic has_rd);
      issue_valid = 1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_has_rd = has_rd;
   endtask

   task automatic test_reset();
      idle(); rst = 1;
      alu_valid = 1; alu_rd = 5; ld_valid = 1; ld_rd = 6; ld_data = 64'h11; issue(0, 0, 2, 1);
      @(negedge clk);
      n_tests++;
      if ({alu_ready, ld_ready, w_enable, issue_ready} !== 4'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 0000",
                            {alu_ready, ld_ready, w_enable, issue_ready});
      end
      n_tests++;
      if (write_value !== 0 || write_entry !== 0) begin
         n_fail++; $display("FAIL reset_port: got %0d/%h want 0/0", write_entry, write_value);
      end
      next(); next(); idle(); rst = 0;
   endtask

   task automatic test_simultaneous();
      alu_valid = 1; alu_rd = 5; alu_data = 64'hA; ld_valid = 1; ld_rd = 6; ld_data = 64'hB;
      @(negedge clk);
      n_tests++;
      if ({ld_ready, alu_ready, w_enable, write_entry, write_value} !== {3'b101, 5'd6, 64'hB}) begin
         n_fail++; $display("FAIL sim_c0: got ld=%b alu=%b we=%b x%0d=%h want 1 0 1 x6=b",
                            ld_ready, alu_ready, w_enable, write_entry, write_value);
      end
      next(); ld_valid = 0;
      @(negedge clk);
      n_tests++;
      if ({ld_ready, alu_ready, w_enable, write_entry, write_value} !== {3'b011, 5'd5, 64'hA}) begin
         n_fail++; $display("FAIL sim_c1: got ld=%b alu=%b we=%b x%0d=%h want 0 1 1 x5=a",
                            ld_ready, alu_ready, w_enable, write_entry, write_value);
      end
      next(); idle();
   endtask

   task automatic test_starvation();
      logic [9:0] got_alu;
      logic [9:0] got_ld;
      alu_valid = 1; alu_rd = 11; ld_valid = 1; ld_rd = 10;
      for (int c = 0; c < 10; c++) begin
         alu_data = 64'(c); ld_data = 64'(c + 100);
         @(negedge clk);
         got_alu[c] = alu_ready; got_ld[c] = ld_ready;
         next();
      end
      idle();
      // ALU wins in cycle 4; counter restarts, so it wins again only in cycle 9.
      n_tests++;
      if (got_alu !== 10'b10_0001_0000) begin
         n_fail++; $display("FAIL starve_alu: got %b want 1000010000", got_alu);
      end
      n_tests++;
      if (got_ld !== 10'b01_1110_1111) begin
         n_fail++; $display("FAIL starve_ld: got %b want 0111101111", got_ld);
      end
   endtask

   task automatic test_rd0();
      issue(0, 0, 12, 1);
      @(negedge clk);
      n_tests++;
      if (issue_ready !== 1'b1) begin
         n_fail++; $display("FAIL rd0_reserve: got %b want 1", issue_ready);
      end
      next(); idle();
      alu_valid = 1; alu_rd = 0; alu_data = 64'h55;
      @(negedge clk);
      n_tests++;
      if ({alu_ready, w_enable} !== 2'b10) begin
         n_fail++; $display("FAIL rd0_write: got ready=%b we=%b want 1 0", alu_ready, w_enable);
      end
      next(); idle(); issue(12, 0, 0, 0);
      @(negedge clk);
      n_tests++;
      if (issue_ready !== 1'b0) begin
         n_fail++; $display("FAIL rd0_busy_kept: got %b want 0", issue_ready);
      end
      next(); idle(); alu_valid = 1; alu_rd = 12; alu_data = 64'hC;
      next(); idle(); issue(12, 0, 0, 0);
      @(negedge clk);
      n_tests++;
      if (issue_ready !== 1'b1) begin
         n_fail++; $display("FAIL rd0_cleared: got %b want 1", issue_ready);
      end
      next(); idle();
   endtask

   task automatic test_raw();
      logic [3:0] got;
      issue(0, 0, 7, 1);
      @(negedge clk); got[0] = issue_ready;
      next(); idle(); issue(7, 0, 0, 0);
      @(negedge clk); got[1] = issue_ready;
      next();
      @(negedge clk); got[2] = issue_ready;
      next(); alu_valid = 1; alu_rd = 7; alu_data = 64'h77;
      @(negedge clk); got[3] = issue_ready;
`ifdef REGFILE_WB_BYPASS_EN
      n_tests++;
      if (got !== 4'b1001) begin
         n_fail++; $display("FAIL raw_ready: got %b want 1001", got);
      end
      n_tests++;
      if (fwd_rs1_hit !== 1'b1 || fwd_data !== 64'h77) begin
         n_fail++; $display("FAIL raw_fwd: got hit=%b data=%h want 1 77", fwd_rs1_hit, fwd_data);
      end
      next(); idle();
`else
      n_tests++;
      if (got !== 4'b0001) begin
         n_fail++; $display("FAIL raw_ready: got %b want 0001", got);
      end
      n_tests++;
      if (fwd_rs1_hit !== 1'b0 || fwd_data !== 0) begin
         n_fail++; $display("FAIL raw_fwd: got hit=%b data=%h want 0 0", fwd_rs1_hit, fwd_data);
      end
      next(); alu_valid = 0;
      @(negedge clk);
      n_tests++;
      if (issue_ready !== 1'b1) begin
         n_fail++; $display("FAIL raw_c4: got %b want 1", issue_ready);
      end
      next(); idle();
`endif
   endtask

   task automatic test_flush();
      issue(0, 0, 3, 1); next();
      issue(0, 0, 9, 1); next();
      idle(); issue(0, 0, 4, 1); flush = 1;
      alu_valid = 1; alu_rd = 20; alu_data = 64'h20;
      @(negedge clk);
      n_tests++;
      if (issue_ready !== 1'b0) begin
         n_fail++; $display("FAIL flush_issue: got %b want 0", issue_ready);
      end
      n_tests++;
      if ({alu_ready, w_enable, write_entry} !== {2'b11, 5'd20}) begin
         n_fail++; $display("FAIL flush_write: got %b %b x%0d want 1 1 x20",
                            alu_ready, w_enable, write_entry);
      end
      next(); idle(); issue(3, 9, 0, 0);
      @(negedge clk);
      n_tests++;
      if (issue_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush_cleared: got %b want 1", issue_ready);
      end
      next(); idle(); issue(4, 0, 0, 0);
      @(negedge clk);
      n_tests++;
      if (issue_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush_no_set: got %b want 1", issue_ready);
      end
      next(); idle();
   endtask

   task automatic test_reset_mid();
      logic [4:0] got_alu;
      issue(0, 0, 15, 1); next(); idle();
      alu_valid = 1; alu_rd = 2; alu_data = 64'h2; ld_valid = 1; ld_rd = 1; ld_data = 64'h1;
      next(); next();
      rst = 1;
      @(negedge clk);
      n_tests++;
      if ({w_enable, ld_ready, alu_ready} !== 3'b000) begin
         n_fail++; $display("FAIL rstmid_we: got %b want 000", {w_enable, ld_ready, alu_ready});
      end
      next(); rst = 0; issue(15, 0, 0, 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         got_alu[c] = alu_ready;
         if (c == 0) begin
            n_tests++;
            if (issue_ready !== 1'b1) begin
               n_fail++; $display("FAIL rstmid_busy: got %b want 1", issue_ready);
            end
         end
         next(); issue_valid = 0;
      end
      n_tests++;
      if (got_alu !== 5'b10000) begin
         n_fail++; $display("FAIL rstmid_wait: got %b want 10000", got_alu);
      end
      idle();
   endtask

   initial begin
      idle(); rst = 1;
      @(posedge clk); #1;
      test_reset();
      test_simultaneous();
      test_starvation();
      test_rd0();
      test_raw();
      test_flush();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
   end

endmodule
